// File: rtl/hsv_core_commit_sequencer.sv
// In-order retirement front end of the commit stage; drives ctrl_* strobes.
// Optional flush watchdog enabled by defining HSV_COMMIT_WDOG_EN.
module hsv_core_commit_sequencer #(
  parameter int TOKEN_W     = 3,
  parameter int WDOG_CYCLES = 256
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [TOKEN_W-1:0] in_token,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_next_pc,
  input  logic               in_trap,
  input  logic [4:0]         in_trap_cause,
  input  logic [31:0]        in_trap_value,
  input  logic               in_jump,
  output logic [TOKEN_W-1:0] commit_token,
  output logic               ctrl_commit,
  output logic               ctrl_trap,
  output logic [4:0]         ctrl_trap_cause,
  output logic [31:0]        ctrl_trap_value,
  output logic [31:0]        ctrl_next_pc,
  output logic               ctrl_flush_begin,
  input  logic               ctrl_begin_irq,
  input  logic               flush_req,
  output logic               flush_ack_commit,
  output logic               wdog_err
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH_WAIT,
    FLUSH_ACK
  } state_t;

  state_t state;
  logic   accept;

  assign ready_o = (state == RUN)
                 & ~flush_req
                 & ~ctrl_begin_irq
                 & (in_token == commit_token);

  assign accept = valid_i & ready_o;

  // Retirement FSM: token tracking, strobe generation and flush handshake
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state            <= RUN;
      commit_token     <= '0;
      ctrl_commit      <= 1'b0;
      ctrl_trap        <= 1'b0;
      ctrl_trap_cause  <= '0;
      ctrl_trap_value  <= '0;
      ctrl_next_pc     <= '0;
      ctrl_flush_begin <= 1'b0;
      flush_ack_commit <= 1'b0;
    end else begin
      ctrl_commit      <= 1'b0;
      ctrl_trap        <= 1'b0;
      ctrl_flush_begin <= 1'b0;
      unique case (state)
        RUN: begin
          if (flush_req) begin
            state            <= FLUSH_ACK;
            flush_ack_commit <= 1'b1;
          end else if (ctrl_begin_irq) begin
            state <= FLUSH_WAIT;
          end else if (accept) begin
            commit_token <= commit_token + TOKEN_W'(1);
            if (in_trap) begin
              ctrl_trap        <= 1'b1;
              ctrl_flush_begin <= 1'b1;
              ctrl_trap_cause  <= in_trap_cause;
              ctrl_trap_value  <= in_trap_value;
              ctrl_next_pc     <= in_pc;
              state            <= FLUSH_WAIT;
            end else if (in_jump) begin
              ctrl_commit      <= 1'b1;
              ctrl_flush_begin <= 1'b1;
              ctrl_next_pc     <= in_next_pc;
              state            <= FLUSH_WAIT;
            end else begin
              ctrl_commit  <= 1'b1;
              ctrl_next_pc <= in_next_pc;
            end
          end
        end
        FLUSH_WAIT: begin
          if (flush_req) begin
            state            <= FLUSH_ACK;
            flush_ack_commit <= 1'b1;
          end
        end
        FLUSH_ACK: begin
          if (!flush_req) begin
            state            <= RUN;
            flush_ack_commit <= 1'b0;
          end
        end
        default: begin
          state            <= RUN;
          flush_ack_commit <= 1'b0;
        end
      endcase
    end
  end

`ifdef HSV_COMMIT_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_q;

  // Count cycles parked in FLUSH_WAIT; flag a flush that never arrives
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else if (state != FLUSH_WAIT) begin
      wdog_cnt <= '0;
    end else begin
      if (wdog_cnt != CNT_W'(WDOG_CYCLES))
        wdog_cnt <= wdog_cnt + CNT_W'(1);
      if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1))
        wdog_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_q;
`else
  // Constant 0 for any positive WDOG_CYCLES; keeps the parameter referenced
  assign wdog_err = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_hsv_core_commit_sequencer.sv
// Directed self-checking bench for hsv_core_commit_sequencer.
// Watchdog expectations follow HSV_COMMIT_WDOG_EN (WDOG_CYCLES=8).
module tb_hsv_core_commit_sequencer;

  localparam int TOKEN_W = 3;

`ifdef HSV_COMMIT_WDOG_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  logic               clk_core;
  logic               rst_core_n;
  logic               valid_i;
  logic               ready_o;
  logic [TOKEN_W-1:0] in_token;
  logic [31:0]        in_pc;
  logic [31:0]        in_next_pc;
  logic               in_trap;
  logic [4:0]         in_trap_cause;
  logic [31:0]        in_trap_value;
  logic               in_jump;
  logic [TOKEN_W-1:0] commit_token;
  logic               ctrl_commit;
  logic               ctrl_trap;
  logic [4:0]         ctrl_trap_cause;
  logic [31:0]        ctrl_trap_value;
  logic [31:0]        ctrl_next_pc;
  logic               ctrl_flush_begin;
  logic               ctrl_begin_irq;
  logic               flush_req;
  logic               flush_ack_commit;
  logic               wdog_err;

  int checks = 0;
  int errors = 0;

  hsv_core_commit_sequencer #(
    .TOKEN_W    (TOKEN_W),
    .WDOG_CYCLES(8)
  ) dut (
    .clk_core        (clk_core),
    .rst_core_n      (rst_core_n),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .in_token        (in_token),
    .in_pc           (in_pc),
    .in_next_pc      (in_next_pc),
    .in_trap         (in_trap),
    .in_trap_cause   (in_trap_cause),
    .in_trap_value   (in_trap_value),
    .in_jump         (in_jump),
    .commit_token    (commit_token),
    .ctrl_commit     (ctrl_commit),
    .ctrl_trap       (ctrl_trap),
    .ctrl_trap_cause (ctrl_trap_cause),
    .ctrl_trap_value (ctrl_trap_value),
    .ctrl_next_pc    (ctrl_next_pc),
    .ctrl_flush_begin(ctrl_flush_begin),
    .ctrl_begin_irq  (ctrl_begin_irq),
    .flush_req       (flush_req),
    .flush_ack_commit(flush_ack_commit),
    .wdog_err        (wdog_err)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic rec(input logic [TOKEN_W-1:0] tok,
                     input logic [31:0] pc,
                     input logic [31:0] npc,
                     input logic trap,
                     input logic jump);
    valid_i    = 1'b1;
    in_token   = tok;
    in_pc      = pc;
    in_next_pc = npc;
    in_trap    = trap;
    in_jump    = jump;
  endtask

  initial begin
    rst_core_n     = 1'b0;
    valid_i        = 1'b0;
    in_token       = '0;
    in_pc          = '0;
    in_next_pc     = '0;
    in_trap        = 1'b0;
    in_trap_cause  = '0;
    in_trap_value  = '0;
    in_jump        = 1'b0;
    ctrl_begin_irq = 1'b0;
    flush_req      = 1'b0;
    tick();
    tick();
    rst_core_n = 1'b1;
    tick();

    // reset values
    chk("rst_token", 64'(commit_token), 64'd0);
    chk("rst_commit", 64'(ctrl_commit), 64'd0);
    chk("rst_trap", 64'(ctrl_trap), 64'd0);
    chk("rst_flush_begin", 64'(ctrl_flush_begin), 64'd0);
    chk("rst_next_pc", 64'(ctrl_next_pc), 64'd0);
    chk("rst_ack", 64'(flush_ack_commit), 64'd0);
    chk("rst_wdog", 64'(wdog_err), 64'd0);

    // 1: three normal records back to back
    rec(3'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    chk("t1_ready0", 64'(ready_o), 64'd1);
    tick();
    chk("t1_commit0", 64'(ctrl_commit), 64'd1);
    chk("t1_npc0", 64'(ctrl_next_pc), 64'h4);
    rec(3'd1, 32'h4, 32'h8, 1'b0, 1'b0);
    tick();
    chk("t1_commit1", 64'(ctrl_commit), 64'd1);
    chk("t1_npc1", 64'(ctrl_next_pc), 64'h8);
    rec(3'd2, 32'h8, 32'hC, 1'b0, 1'b0);
    tick();
    chk("t1_commit2", 64'(ctrl_commit), 64'd1);
    chk("t1_npc2", 64'(ctrl_next_pc), 64'hC);
    chk("t1_token", 64'(commit_token), 64'd3);
    valid_i = 1'b0;
    tick();
    chk("t1_idle_commit", 64'(ctrl_commit), 64'd0);
    chk("t1_npc_held", 64'(ctrl_next_pc), 64'hC);

    // 2: out-of-order token stalls, then in-order retire
    rec(3'd4, 32'h10, 32'h14, 1'b0, 1'b0);
    #1;
    chk("t2_ready_mismatch", 64'(ready_o), 64'd0);
    tick();
    chk("t2_no_commit", 64'(ctrl_commit), 64'd0);
    chk("t2_token_held", 64'(commit_token), 64'd3);
    rec(3'd3, 32'hC, 32'h10, 1'b0, 1'b0);
    tick();
    chk("t2_commit3", 64'(ctrl_commit), 64'd1);
    chk("t2_npc3", 64'(ctrl_next_pc), 64'h10);
    rec(3'd4, 32'h10, 32'h14, 1'b0, 1'b0);
    tick();
    chk("t2_commit4", 64'(ctrl_commit), 64'd1);
    chk("t2_token5", 64'(commit_token), 64'd5);

    // 3: trap record
    rec(3'd5, 32'h100, 32'h104, 1'b1, 1'b0);
    in_trap_cause = 5'd2;
    in_trap_value = 32'hDEAD;
    tick();
    chk("t3_trap", 64'(ctrl_trap), 64'd1);
    chk("t3_flush_begin", 64'(ctrl_flush_begin), 64'd1);
    chk("t3_commit", 64'(ctrl_commit), 64'd0);
    chk("t3_npc", 64'(ctrl_next_pc), 64'h100);
    chk("t3_cause", 64'(ctrl_trap_cause), 64'd2);
    chk("t3_value", 64'(ctrl_trap_value), 64'hDEAD);
    chk("t3_token", 64'(commit_token), 64'd6);
    in_trap_cause = '0;
    in_trap_value = '0;
    rec(3'd6, 32'h104, 32'h2000, 1'b0, 1'b1);
    tick();
    chk("t3_trap_pulse", 64'(ctrl_trap), 64'd0);
    chk("t3_fb_pulse", 64'(ctrl_flush_begin), 64'd0);
    chk("t3_wait_ready", 64'(ready_o), 64'd0);
    tick();
    tick();
    flush_req = 1'b1;
    tick();
    chk("t3_ack", 64'(flush_ack_commit), 64'd1);
    chk("t3_ack_no_commit", 64'(ctrl_commit), 64'd0);
    chk("t3_ack_ready", 64'(ready_o), 64'd0);
    flush_req = 1'b0;
    tick();
    chk("t3_ack_drop", 64'(flush_ack_commit), 64'd0);
    chk("t3_run_ready", 64'(ready_o), 64'd1);
    chk("t3_token_kept", 64'(commit_token), 64'd6);

    // 4: jump record (pending since test 3)
    tick();
    chk("t4_commit", 64'(ctrl_commit), 64'd1);
    chk("t4_flush_begin", 64'(ctrl_flush_begin), 64'd1);
    chk("t4_npc", 64'(ctrl_next_pc), 64'h2000);
    chk("t4_token", 64'(commit_token), 64'd7);
    rec(3'd7, 32'h2000, 32'h2004, 1'b0, 1'b0);
    #1;
    chk("t4_stall_ready", 64'(ready_o), 64'd0);
    tick();
    chk("t4_stall_commit", 64'(ctrl_commit), 64'd0);
    chk("t4_stall_npc", 64'(ctrl_next_pc), 64'h2000);
    flush_req = 1'b1;
    tick();
    chk("t4_ack", 64'(flush_ack_commit), 64'd1);
    flush_req = 1'b0;
    tick();
    chk("t4_ack_drop", 64'(flush_ack_commit), 64'd0);
    tick();
    chk("t4_commit7", 64'(ctrl_commit), 64'd1);
    chk("t4_npc7", 64'(ctrl_next_pc), 64'h2004);
    chk("t4_token_wrap", 64'(commit_token), 64'd0);

    // 5a: interrupt overrides a pending record
    rec(3'd0, 32'h2004, 32'h2008, 1'b0, 1'b0);
    ctrl_begin_irq = 1'b1;
    #1;
    chk("t5_irq_ready", 64'(ready_o), 64'd0);
    tick();
    ctrl_begin_irq = 1'b0;
    chk("t5_irq_commit", 64'(ctrl_commit), 64'd0);
    chk("t5_irq_token", 64'(commit_token), 64'd0);
    chk("t5_irq_wait", 64'(ready_o), 64'd0);
    tick();
    chk("t5_irq_hold", 64'(ctrl_commit), 64'd0);
    flush_req = 1'b1;
    tick();
    chk("t5_irq_ack", 64'(flush_ack_commit), 64'd1);
    flush_req = 1'b0;
    tick();
    chk("t5_irq_ack_drop", 64'(flush_ack_commit), 64'd0);
    tick();
    chk("t5_pending_commit", 64'(ctrl_commit), 64'd1);
    chk("t5_pending_npc", 64'(ctrl_next_pc), 64'h2008);
    chk("t5_pending_token", 64'(commit_token), 64'd1);

    // 5b: unsolicited flush in RUN overrides a valid record
    rec(3'd1, 32'h2008, 32'h200C, 1'b0, 1'b0);
    flush_req = 1'b1;
    #1;
    chk("t5_uf_ready", 64'(ready_o), 64'd0);
    tick();
    chk("t5_uf_ack", 64'(flush_ack_commit), 64'd1);
    chk("t5_uf_no_fb", 64'(ctrl_flush_begin), 64'd0);
    chk("t5_uf_no_commit", 64'(ctrl_commit), 64'd0);
    chk("t5_uf_token", 64'(commit_token), 64'd1);
    valid_i   = 1'b0;
    flush_req = 1'b0;
    tick();
    chk("t5_uf_ack_drop", 64'(flush_ack_commit), 64'd0);

    // 6: watchdog on a withheld flush, then reset mid-FLUSH_ACK
    rec(3'd1, 32'h300, 32'h304, 1'b1, 1'b0);
    in_trap_cause = 5'd7;
    in_trap_value = 32'hBEEF;
    tick();
    valid_i = 1'b0;
    chk("t6_trap", 64'(ctrl_trap), 64'd1);
    chk("t6_trap_npc", 64'(ctrl_next_pc), 64'h300);
    for (int i = 0; i < 7; i++) tick();
    chk("t6_wdog_early", 64'(wdog_err), 64'd0);
    tick();
    chk("t6_wdog_fire", 64'(wdog_err), 64'(WDOG_ON));
    flush_req = 1'b1;
    tick();
    chk("t6_ack", 64'(flush_ack_commit), 64'd1);
    chk("t6_wdog_sticky", 64'(wdog_err), 64'(WDOG_ON));
    tick();
    chk("t6_ack_hold", 64'(flush_ack_commit), 64'd1);
    #2;
    rst_core_n = 1'b0;
    #1;
    chk("t6_rst_ack", 64'(flush_ack_commit), 64'd0);
    chk("t6_rst_wdog", 64'(wdog_err), 64'd0);
    chk("t6_rst_token", 64'(commit_token), 64'd0);
    chk("t6_rst_npc", 64'(ctrl_next_pc), 64'd0);
    chk("t6_rst_cause", 64'(ctrl_trap_cause), 64'd0);
    chk("t6_rst_value", 64'(ctrl_trap_value), 64'd0);
    flush_req = 1'b0;
    tick();
    rst_core_n = 1'b1;
    tick();
    rec(3'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    #1;
    chk("t6_post_ready", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    chk("t6_post_commit", 64'(ctrl_commit), 64'd1);
    chk("t6_post_token", 64'(commit_token), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
